// File: rtl/affine_mac_lanes.sv
// Multi-lane multiply-accumulate unit: lanes are processed one per cycle through
// two multipliers and one shared adder, with valid/ready handshakes on both sides.
module affine_mac_lanes #(
    parameter int N     = 8,
    parameter int LANES = 2,
    parameter int SAT   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [LANES*N-1:0]   x,
    input  logic [LANES*N-1:0]   y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   r,
    output logic                 ovf,
    output logic                 busy
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [N-1:0]  MAX_V = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  MIN_V = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MAC = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_ADD = 2'd2;

    // Reduce a full-width product to N bits; MSB of the result flags a non-fitting value.
    function automatic logic [N:0] reduce_prod(input logic [2*N-1:0] p);
        logic       fits_s;
        logic [N:0] res_s;
        fits_s = (p[2*N-1:N-1] == {(N+1){1'b0}}) || (p[2*N-1:N-1] == {(N+1){1'b1}});
        if (fits_s) begin
            res_s = {1'b0, p[N-1:0]};
        end else if (SAT != 0) begin
            res_s = {1'b1, (p[2*N-1] ? MIN_V : MAX_V)};
        end else begin
            res_s = {1'b1, p[N-1:0]};
        end
        return res_s;
    endfunction

    // Same reduction for an N+1 bit sum.
    function automatic logic [N:0] reduce_sum(input logic [N:0] s);
        logic [N:0] res_s;
        if (s[N] == s[N-1]) begin
            res_s = {1'b0, s[N-1:0]};
        end else if (SAT != 0) begin
            res_s = {1'b1, (s[N] ? MIN_V : MAX_V)};
        end else begin
            res_s = {1'b1, s[N-1:0]};
        end
        return res_s;
    endfunction

    state_t          state_r;
    logic [LW-1:0]   lane_r;
    logic [1:0]      op_r;
    logic [LANES*N-1:0] x_r;
    logic [LANES*N-1:0] y_r;
    logic [N-1:0]    acc_r [LANES];
    logic            ovf_acc_r;
    logic            ovf_r;
    logic            out_valid_r;
    logic            in_ready_r;
    logic            busy_r;

    logic [LW-1:0]   lane_b_s;
    logic [N-1:0]    xa_s, ya_s, xb_s, yb_s;
    logic [2*N-1:0]  p0_full_s, p1_full_s;
    logic [N:0]      p0_s, p1_s, sum_s;
    logic [N-1:0]    add_a_s, add_b_s;
    logic            prod_ovf_s;
    logic            lane_ovf_s;

    // Datapath for the lane currently in flight: two multipliers and the shared adder.
    always_comb begin
        lane_b_s   = (lane_r == LAST_LANE) ? {LW{1'b0}} : lane_r + LW'(1);
        xa_s       = x_r[lane_r*N +: N];
        ya_s       = y_r[lane_r*N +: N];
        xb_s       = x_r[lane_b_s*N +: N];
        yb_s       = y_r[lane_b_s*N +: N];
        p0_full_s  = {{N{xa_s[N-1]}}, xa_s} * {{N{ya_s[N-1]}}, ya_s};
        p1_full_s  = {{N{xb_s[N-1]}}, xb_s} * {{N{yb_s[N-1]}}, yb_s};
        p0_s       = reduce_prod(p0_full_s);
        p1_s       = reduce_prod(p1_full_s);
        add_a_s    = {N{1'b0}};
        add_b_s    = {N{1'b0}};
        prod_ovf_s = 1'b0;
        case (op_r)
            OP_MAC: begin
                add_a_s    = acc_r[lane_r];
                add_b_s    = p0_s[N-1:0];
                prod_ovf_s = p0_s[N];
            end
            OP_MUL: begin
                add_b_s    = p0_s[N-1:0];
                prod_ovf_s = p0_s[N];
            end
            OP_ADD: begin
                add_a_s    = p0_s[N-1:0];
                add_b_s    = p1_s[N-1:0];
                prod_ovf_s = p0_s[N] | p1_s[N];
            end
            default: begin
                add_a_s    = {N{1'b0}};
                add_b_s    = {N{1'b0}};
                prod_ovf_s = 1'b0;
            end
        endcase
        sum_s      = reduce_sum({add_a_s[N-1], add_a_s} + {add_b_s[N-1], add_b_s});
        lane_ovf_s = prod_ovf_s | sum_s[N];
    end

    // Control FSM, accumulators and registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            lane_r      <= {LW{1'b0}};
            op_r        <= 2'd0;
            x_r         <= {(LANES*N){1'b0}};
            y_r         <= {(LANES*N){1'b0}};
            for (int i = 0; i < LANES; i++) acc_r[i] <= {N{1'b0}};
            ovf_acc_r   <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r       <= op;
                        x_r        <= x;
                        y_r        <= y;
                        ovf_acc_r  <= 1'b0;
                        lane_r     <= {LW{1'b0}};
                        state_r    <= COMP;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                COMP: begin
                    acc_r[lane_r] <= sum_s[N-1:0];
                    if (lane_r == LAST_LANE) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        ovf_r       <= ovf_acc_r | lane_ovf_s;
                    end else begin
                        lane_r    <= lane_r + LW'(1);
                        ovf_acc_r <= ovf_acc_r | lane_ovf_s;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_r
        assign r[l*N +: N] = acc_r[l];
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign ovf       = ovf_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_affine_mac_lanes.sv
// Bench for affine_mac_lanes: three builds (wrap, saturating, single lane) driven in
// lockstep and checked every cycle against an integer reference model.
module tb_affine_mac_lanes;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  op;
    logic [15:0] x_ab, y_ab;
    logic [7:0]  x_c, y_c;
    logic [15:0] r_a, r_b;
    logic [7:0]  r_c;
    logic [2:0]  vld, rdy, bsy, ovf;

    int  n_cmp = 0;
    int  n_fail = 0;
    int  acc_m [3][2];
    int  ovf_m [3];
    int  ovf_cap [3];
    int  xs [2];
    int  ys [2];
    bit  chk_en = 1'b0;

    affine_mac_lanes #(.N(8), .LANES(2), .SAT(0)) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .op(op),
        .x(x_ab), .y(y_ab), .out_valid(vld[0]), .out_ready(out_ready), .r(r_a),
        .ovf(ovf[0]), .busy(bsy[0]));

    affine_mac_lanes #(.N(8), .LANES(2), .SAT(1)) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .op(op),
        .x(x_ab), .y(y_ab), .out_valid(vld[1]), .out_ready(out_ready), .r(r_b),
        .ovf(ovf[1]), .busy(bsy[1]));

    affine_mac_lanes #(.N(8), .LANES(1), .SAT(0)) dut_c (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]), .op(op),
        .x(x_c), .y(y_c), .out_valid(vld[2]), .out_ready(out_ready), .r(r_c),
        .ovf(ovf[2]), .busy(bsy[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
        end
    endtask

    function automatic int lanes_of(input int d);
        return (d == 2) ? 1 : 2;
    endfunction

    function automatic int get_r(input int d, input int l);
        logic [7:0] b;
        if (d == 0) b = r_a[8*l +: 8];
        else if (d == 1) b = r_b[8*l +: 8];
        else b = r_c;
        return int'($signed(b));
    endfunction

    function automatic bit fits(input int v);
        return (v <= 127) && (v >= -128);
    endfunction

    function automatic int red(input int v, input bit sat);
        int w;
        if (fits(v)) return v;
        if (sat) return (v > 127) ? 127 : -128;
        w = v & 255;
        if (w >= 128) w = w - 256;
        return w;
    endfunction

    // Reference model: apply one operation to every build's accumulators.
    task automatic model_apply(input int opc);
        for (int d = 0; d < 3; d++) begin
            int  nl;
            int  raw0, raw1, p0, p1, s;
            bit  sat, ov;
            sat = (d == 1);
            ov  = 1'b0;
            for (int l = 0; l < lanes_of(d); l++) begin
                nl   = (l + 1) % lanes_of(d);
                raw0 = xs[l] * ys[l];
                raw1 = xs[nl] * ys[nl];
                p0   = red(raw0, sat);
                p1   = red(raw1, sat);
                case (opc)
                    0: begin ov |= !fits(raw0); s = acc_m[d][l] + p0; end
                    1: begin ov |= !fits(raw0); s = p0; end
                    2: begin ov |= !fits(raw0) || !fits(raw1); s = p0 + p1; end
                    default: s = 0;
                endcase
                ov |= !fits(s);
                acc_m[d][l] = red(s, sat);
            end
            ovf_m[d] = ov;
        end
    endtask

    // Per-cycle compare of all three builds against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                if (vld[d]) begin
                    chk("done_in_ready", d, int'(rdy[d]), 0);
                    chk("done_busy", d, int'(bsy[d]), 1);
                    chk("done_ovf", d, int'(ovf[d]), ovf_m[d]);
                    for (int l = 0; l < lanes_of(d); l++)
                        chk("done_r", d, get_r(d, l), acc_m[d][l]);
                end else if (!bsy[d]) begin
                    chk("idle_in_ready", d, int'(rdy[d]), 1);
                    for (int l = 0; l < lanes_of(d); l++)
                        chk("idle_r", d, get_r(d, l), acc_m[d][l]);
                end
            end
        end
    end

    // Issue one op to all builds, check latency, optionally hold off the consumer.
    task automatic do_op(input int opc, input int x0, input int y0, input int x1,
                         input int y1, input int hold);
        int lat [3];
        xs[0] = x0; ys[0] = y0; xs[1] = x1; ys[1] = y1;
        op       = 2'(opc);
        x_ab     = {8'(x1), 8'(x0)};
        y_ab     = {8'(y1), 8'(y0)};
        x_c      = 8'(x0);
        y_c      = 8'(y0);
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        model_apply(opc);
        op   = 2'($urandom_range(3));
        x_ab = 16'($urandom);
        y_ab = 16'($urandom);
        x_c  = 8'($urandom);
        y_c  = 8'($urandom);
        for (int d = 0; d < 3; d++) lat[d] = 0;
        for (int c = 1; c <= 8; c++) begin
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
            @(posedge clock); #1;
            for (int d = 0; d < 3; d++)
                if (vld[d] && lat[d] == 0) begin
                    lat[d] = c;
                    ovf_cap[d] = int'(ovf[d]);
                end
        end
        for (int d = 0; d < 3; d++) chk("latency", d, lat[d], lanes_of(d));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(1));
            x_ab = 16'($urandom);
            y_ab = 16'($urandom);
            x_c  = 8'($urandom);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        if (hold > 0)
            for (int d = 0; d < 3; d++) chk("hold_valid", d, int'(vld[d]), 1);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("release_valid", d, int'(vld[d]), 0);
            chk("release_busy", d, int'(bsy[d]), 0);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            acc_m[d][0] = 0;
            acc_m[d][1] = 0;
            ovf_m[d] = 0;
        end
    endtask

    task automatic chk_reset_state(input string nm);
        for (int d = 0; d < 3; d++) begin
            chk({nm, "_valid"}, d, int'(vld[d]), 0);
            chk({nm, "_busy"}, d, int'(bsy[d]), 0);
            chk({nm, "_in_ready"}, d, int'(rdy[d]), 1);
            for (int l = 0; l < lanes_of(d); l++) chk({nm, "_r"}, d, get_r(d, l), 0);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'd0;
        x_ab = 16'd0; y_ab = 16'd0; x_c = 8'd0; y_c = 8'd0;
        model_clear();
        #1;
        chk_reset_state("reset");
        chk_en = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        do_op(1, 3, -4, 5, 6, 0);
        chk("pin_mul_r0", 0, get_r(0, 0), -12);
        chk("pin_mul_r1", 0, get_r(0, 1), 30);
        chk("pin_mul_ovf", 0, ovf_cap[0], 0);

        do_op(0, 2, 10, 1, -30, 0);
        chk("pin_mac_r0", 0, get_r(0, 0), 8);
        chk("pin_mac_r1", 0, get_r(0, 1), 0);
        chk("pin_mac_ovf", 0, ovf_cap[0], 0);

        do_op(2, 3, 4, 5, 6, 0);
        chk("pin_add_r0", 0, get_r(0, 0), 42);
        chk("pin_add_r1", 0, get_r(0, 1), 42);
        chk("pin_add_l1", 2, get_r(2, 0), 24);

        do_op(3, 9, 9, 9, 9, 0);
        do_op(1, 16, 16, 0, 0, 0);
        chk("pin_ovf_wrap_r0", 0, get_r(0, 0), 0);
        chk("pin_ovf_wrap", 0, ovf_cap[0], 1);
        chk("pin_ovf_sat_r0", 1, get_r(1, 0), 127);
        chk("pin_ovf_sat", 1, ovf_cap[1], 1);
        do_op(0, -128, 1, 0, 0, 0);
        chk("pin_sat_mac_r0", 1, get_r(1, 0), -1);
        chk("pin_sat_mac_ovf", 1, ovf_cap[1], 0);
        chk("pin_wrap_mac_r0", 0, get_r(0, 0), -128);

        do_op(0, 7, 3, -2, 5, 5);
        do_op(3, 1, 1, 1, 1, 0);
        chk("pin_clr_r0", 0, get_r(0, 0), 0);
        chk("pin_clr_r1", 0, get_r(0, 1), 0);

        for (int i = 0; i < 150; i++) begin
            int v [4];
            for (int k = 0; k < 4; k++)
                v[k] = (i % 2 == 0) ? int'($urandom_range(255)) - 128
                                    : int'($urandom_range(24)) - 12;
            do_op(int'($urandom_range(3)), v[0], v[1], v[2], v[3],
                  int'($urandom_range(2)));
        end

        // Reset while the first lane is written and the second is pending.
        xs[0] = 5; ys[0] = 5; xs[1] = -3; ys[1] = 4;
        op = 2'd1; x_ab = {8'(-3), 8'(5)}; y_ab = {8'(4), 8'(5)};
        x_c = 8'(5); y_c = 8'(5);
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        model_apply(1);
        @(posedge clock); #1;
        reset = 1'b1;
        model_clear();
        #1;
        chk_reset_state("midreset");
        @(posedge clock); #1;
        reset = 1'b0;

        do_op(1, 5, 5, -3, 4, 0);
        chk("pin_post_reset_r0", 0, get_r(0, 0), 25);
        chk("pin_post_reset_r1", 0, get_r(0, 1), -12);

        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
